ram_rd_arbiter: RTL and testbench

RAM_RD_ARBITER -- requirements
Module: ram_rd_arbiter

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/rsp_slot.sv | 72 +++++++
 rtl/ram_rd_arbiter.sv | 116 +++++++++++
 tb/tb_ram_rd_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the two-client RAM read arbiter: client indices and
// the round-robin priority pointer type.
// ---------------------------------------------------------------------------
package ram_arb_pkg;

   localparam int CLIENT0 = 0;
   localparam int CLIENT1 = 1;
   localparam int NCLIENT = 2;

   // Names the client that wins the next tie.
   typedef enum logic {
      PRIO_C0 = 1'b0,
      PRIO_C1 = 1'b1
   } prio_t;

   // After a grant the other client gets priority.
   function automatic prio_t prio_after(input int granted);
      return (granted == CLIENT0) ? PRIO_C1 : PRIO_C0;
   endfunction

endpackage

// File: rtl/rsp_slot.sv
// ---------------------------------------------------------------------------
// rsp_slot
// Per-client response slot. Tracks the single read this client may have in
// flight, captures the RAM data one cycle after the grant and holds it until
// the client consumes it.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   req_valid_i   client presents a read request
//   grant_i       arbiter granted this client in the current cycle
//   rsp_ready_i   client consumes the response this cycle
//   ram_do_i      registered RAM read data
//   eligible_o    client may be granted this cycle
//   rsp_valid_o   response register holds unconsumed data
//   rsp_data_o    response data
// ---------------------------------------------------------------------------
module rsp_slot
   import ram_arb_pkg::*;
#(
   parameter int DWIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid_i,
   input  logic              grant_i,
   input  logic              rsp_ready_i,
   input  logic [DWIDTH-1:0] ram_do_i,
   output logic              eligible_o,
   output logic              rsp_valid_o,
   output logic [DWIDTH-1:0] rsp_data_o
);

   logic              inflight_q,  inflight_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DWIDTH-1:0] rsp_data_q,  rsp_data_d;

   // A new grant is only possible when the response register is empty or
   // being drained in the same cycle, so the capture never overwrites
   // unconsumed data.
   assign eligible_o = req_valid_i & ~inflight_q & (~rsp_valid_q | rsp_ready_i);

   always_comb begin
      // The flag lives exactly one cycle: the cycle in which ram_do is valid.
      inflight_d  = grant_i;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      if (rsp_valid_q && rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
      // Capture takes precedence over the consume-clear at the same edge.
      if (inflight_q) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = ram_do_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inflight_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         inflight_q  <= inflight_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;

endmodule

// File: rtl/ram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ram_rd_arbiter
// Shares one RAM read port between two clients with round-robin arbitration.
// Fixed latency of two cycles from request handshake to rsp_valid.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cN_req_valid/addr/ready     request channel of client N
//   cN_rsp_valid/data/ready     response channel of client N
//   ram_rden, ram_rdaddr        RAM read port (address held when idle)
//   ram_do                      RAM registered read data (1-cycle latency)
// ---------------------------------------------------------------------------
module ram_rd_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c0_req_valid,
   input  logic [AWIDTH-1:0] c0_req_addr,
   output logic              c0_req_ready,
   output logic              c0_rsp_valid,
   output logic [DWIDTH-1:0] c0_rsp_data,
   input  logic              c0_rsp_ready,
   input  logic              c1_req_valid,
   input  logic [AWIDTH-1:0] c1_req_addr,
   output logic              c1_req_ready,
   output logic              c1_rsp_valid,
   output logic [DWIDTH-1:0] c1_rsp_data,
   input  logic              c1_rsp_ready,
   output logic              ram_rden,
   output logic [AWIDTH-1:0] ram_rdaddr,
   input  logic [DWIDTH-1:0] ram_do
);

   logic [NCLIENT-1:0] req_valid;
   logic [NCLIENT-1:0] rsp_ready;
   logic [NCLIENT-1:0] eligible;
   logic [NCLIENT-1:0] grant;
   logic [NCLIENT-1:0] rsp_valid;
   logic [AWIDTH-1:0]  req_addr  [NCLIENT];
   logic [DWIDTH-1:0]  rsp_data  [NCLIENT];

   prio_t             prio_q,   prio_d;
   logic [AWIDTH-1:0] rdaddr_q, rdaddr_d;

   assign req_valid         = {c1_req_valid, c0_req_valid};
   assign rsp_ready         = {c1_rsp_ready, c0_rsp_ready};
   assign req_addr[CLIENT0] = c0_req_addr;
   assign req_addr[CLIENT1] = c1_req_addr;

   // One response slot per client.
   for (genvar gi = 0; gi < NCLIENT; gi++) begin : g_slot
      rsp_slot #(
         .DWIDTH (DWIDTH)
      ) u_slot (
         .clk         (clk),
         .reset       (reset),
         .req_valid_i (req_valid[gi]),
         .grant_i     (grant[gi]),
         .rsp_ready_i (rsp_ready[gi]),
         .ram_do_i    (ram_do),
         .eligible_o  (eligible[gi]),
         .rsp_valid_o (rsp_valid[gi]),
         .rsp_data_o  (rsp_data[gi])
      );
   end

   // Grant: a lone eligible client wins outright; on a tie the pointer decides.
   always_comb begin
      grant = '0;
      if (!reset) begin
         if (eligible[CLIENT0] && (!eligible[CLIENT1] || prio_q == PRIO_C0)) begin
            grant[CLIENT0] = 1'b1;
         end else if (eligible[CLIENT1]) begin
            grant[CLIENT1] = 1'b1;
         end
      end
   end

   // Pointer and RAM address follow the grant; the address holds when idle.
   always_comb begin
      prio_d   = prio_q;
      rdaddr_d = rdaddr_q;
      if (grant[CLIENT0]) begin
         prio_d   = prio_after(CLIENT0);
         rdaddr_d = req_addr[CLIENT0];
      end else if (grant[CLIENT1]) begin
         prio_d   = prio_after(CLIENT1);
         rdaddr_d = req_addr[CLIENT1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q   <= PRIO_C0;
         rdaddr_q <= '0;
      end else begin
         prio_q   <= prio_d;
         rdaddr_q <= rdaddr_d;
      end
   end

   assign ram_rden     = |grant;
   assign ram_rdaddr   = rdaddr_d;

   assign c0_req_ready = grant[CLIENT0];
   assign c1_req_ready = grant[CLIENT1];
   assign c0_rsp_valid = rsp_valid[CLIENT0];
   assign c1_rsp_valid = rsp_valid[CLIENT1];
   assign c0_rsp_data  = rsp_data[CLIENT0];
   assign c1_rsp_data  = rsp_data[CLIENT1];

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_rd_arbiter
// Directed stimulus for ram_rd_arbiter. Each request handshake pushes the
// expected read data into a per-client queue; a monitor per client pops and
// compares when the response is consumed, and also checks the two-cycle
// latency and that the response holds steady while stalled.
// ---------------------------------------------------------------------------
module tb_ram_rd_arbiter;

   localparam int DW = 16;
   localparam int AW = 7;

   logic          clk;
   logic          reset;
   logic          c0_req_valid, c1_req_valid;
   logic [AW-1:0] c0_req_addr,  c1_req_addr;
   logic          c0_req_ready, c1_req_ready;
   logic          c0_rsp_valid, c1_rsp_valid;
   logic [DW-1:0] c0_rsp_data,  c1_rsp_data;
   logic          c0_rsp_ready, c1_rsp_ready;
   logic          ram_rden;
   logic [AW-1:0] ram_rdaddr;
   logic [DW-1:0] ram_do;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int pend_cnt [2];

   ram_rd_arbiter #(
      .DWIDTH (DW),
      .AWIDTH (AW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .c0_req_valid (c0_req_valid),
      .c0_req_addr  (c0_req_addr),
      .c0_req_ready (c0_req_ready),
      .c0_rsp_valid (c0_rsp_valid),
      .c0_rsp_data  (c0_rsp_data),
      .c0_rsp_ready (c0_rsp_ready),
      .c1_req_valid (c1_req_valid),
      .c1_req_addr  (c1_req_addr),
      .c1_req_ready (c1_req_ready),
      .c1_rsp_valid (c1_rsp_valid),
      .c1_rsp_data  (c1_rsp_data),
      .c1_rsp_ready (c1_rsp_ready),
      .ram_rden     (ram_rden),
      .ram_rdaddr   (ram_rdaddr),
      .ram_do       (ram_do)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM contents: addr1/2/3 fixed, every other word is 0xC000 | addr.
   function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
      case (a)
         7'd1:    return 16'hAAAA;
         7'd2:    return 16'h5555;
         7'd3:    return 16'hFFFF;
         default: return 16'hC000 | {9'd0, a};
      endcase
   endfunction

   logic [DW-1:0] mem [2**AW];
   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = ram_word(AW'(i));
   end
   always @(posedge clk) if (ram_rden) ram_do <= mem[ram_rdaddr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- scoreboard / monitors ----------------
   logic [1:0]    req_v, req_r, rsp_v, rsp_r;
   logic [AW-1:0] req_a [2];
   logic [DW-1:0] rsp_d [2];
   assign req_v = {c1_req_valid, c0_req_valid};
   assign req_r = {c1_req_ready, c0_req_ready};
   assign rsp_v = {c1_rsp_valid, c0_rsp_valid};
   assign rsp_r = {c1_rsp_ready, c0_rsp_ready};
   assign req_a[0] = c0_req_addr;
   assign req_a[1] = c1_req_addr;
   assign rsp_d[0] = c0_rsp_data;
   assign rsp_d[1] = c1_rsp_data;

   typedef struct {
      logic [DW-1:0] data;
      int            hs_cyc;
   } exp_t;

   for (genvar gi = 0; gi < 2; gi++) begin : g_mon
      exp_t          q [$];
      logic          new_rsp = 1'b1;
      logic [DW-1:0] held;
      exp_t          e;
      always @(negedge clk) begin
         if (reset) begin
            q.delete();
            new_rsp = 1'b1;
         end else begin
            if (req_v[gi] && req_r[gi]) begin
               e.data   = ram_word(req_a[gi]);
               e.hs_cyc = cyc;
               q.push_back(e);
               $display("c%0d request addr %0d accepted at cyc %0d", gi, req_a[gi], cyc);
            end
            if (rsp_v[gi]) begin
               if (new_rsp) begin
                  chk($sformatf("c%0d_rsp_expected", gi), (q.size() != 0), 1);
                  if (q.size() != 0)
                     chk($sformatf("c%0d_latency", gi), cyc, q[0].hs_cyc + 2);
                  held = rsp_d[gi];
               end else begin
                  chk($sformatf("c%0d_rsp_hold", gi), rsp_d[gi], held);
               end
               if (rsp_r[gi] && q.size() != 0) begin
                  e = q.pop_front();
                  chk($sformatf("c%0d_rsp_data", gi), rsp_d[gi], e.data);
                  $display("c%0d response %h consumed at cyc %0d", gi, rsp_d[gi], cyc);
               end
               new_rsp = rsp_r[gi];
            end else begin
               new_rsp = 1'b1;
            end
         end
         pend_cnt[gi] = q.size();
      end
   end

   // RAM port: rden only on a grant, address of the granted client, else held.
   logic [AW-1:0] last_addr = '0;
   always @(negedge clk) begin
      logic          hs0, hs1;
      logic [AW-1:0] ea;
      if (reset) begin
         last_addr = '0;
      end else begin
         hs0 = c0_req_valid & c0_req_ready;
         hs1 = c1_req_valid & c1_req_ready;
         chk("single_grant", {31'd0, hs0 & hs1}, 0);
         chk("ram_rden", {31'd0, ram_rden}, {31'd0, hs0 | hs1});
         ea = hs0 ? c0_req_addr : (hs1 ? c1_req_addr : last_addr);
         chk("ram_rdaddr", {25'd0, ram_rdaddr}, {25'd0, ea});
         last_addr = ea;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) nxt();
      reset = 1'b0;
   endtask

   int c0_cnt;
   logic [AW-1:0] a0, a1;

   initial begin
      reset        = 1'b1;
      c0_req_valid = 1'b1;  c0_req_addr = 7'd1;  c0_rsp_ready = 1'b0;
      c1_req_valid = 1'b1;  c1_req_addr = 7'd2;  c1_rsp_ready = 1'b0;

      // Reset state: nothing granted even with requests pending.
      repeat (2) nxt();
      smp();
      chk("rst_c0_req_ready", {31'd0, c0_req_ready}, 0);
      chk("rst_c1_req_ready", {31'd0, c1_req_ready}, 0);
      chk("rst_ram_rden",     {31'd0, ram_rden}, 0);
      chk("rst_c0_rsp_valid", {31'd0, c0_rsp_valid}, 0);
      chk("rst_c1_rsp_valid", {31'd0, c1_rsp_valid}, 0);
      chk("rst_ram_rdaddr",   {25'd0, ram_rdaddr}, 0);
      nxt();
      c0_req_valid = 1'b0;  c1_req_valid = 1'b0;
      c0_rsp_ready = 1'b1;  c1_rsp_ready = 1'b1;
      reset = 1'b0;
      nxt();

      // Single c0 read of addr1.
      c0_req_valid = 1'b1;  c0_req_addr = 7'd1;
      smp();
      chk("t1_c0_req_ready", {31'd0, c0_req_ready}, 1);
      chk("t1_rden",         {31'd0, ram_rden}, 1);
      chk("t1_rdaddr",       {25'd0, ram_rdaddr}, 1);
      nxt();
      c0_req_valid = 1'b0;
      smp();
      chk("t1_idle_rden",    {31'd0, ram_rden}, 0);
      chk("t1_hold_rdaddr",  {25'd0, ram_rdaddr}, 1);
      chk("t1_n1_rsp_valid", {31'd0, c0_rsp_valid}, 0);
      nxt();
      smp();
      chk("t1_n2_rsp_valid", {31'd0, c0_rsp_valid}, 1);
      chk("t1_n2_rsp_data",  {16'd0, c0_rsp_data}, 32'hAAAA);
      nxt();
      smp();
      chk("t1_n3_rsp_valid", {31'd0, c0_rsp_valid}, 0);
      nxt();

      // Tie straight after reset: c0 first, then c1.
      do_reset(2);
      c0_req_valid = 1'b1;  c0_req_addr = 7'd1;
      c1_req_valid = 1'b1;  c1_req_addr = 7'd2;
      smp();
      chk("t2_c0_first", {31'd0, c0_req_ready}, 1);
      chk("t2_c1_wait",  {31'd0, c1_req_ready}, 0);
      nxt();
      c0_req_valid = 1'b0;
      smp();
      chk("t2_c1_second", {31'd0, c1_req_ready}, 1);
      chk("t2_rdaddr",    {25'd0, ram_rdaddr}, 2);
      nxt();
      c1_req_valid = 1'b0;
      smp();
      chk("t2_c0_rsp_valid", {31'd0, c0_rsp_valid}, 1);
      chk("t2_c0_rsp_data",  {16'd0, c0_rsp_data}, 32'hAAAA);
      chk("t2_c1_rsp_early", {31'd0, c1_rsp_valid}, 0);
      nxt();
      smp();
      chk("t2_c1_rsp_valid", {31'd0, c1_rsp_valid}, 1);
      chk("t2_c1_rsp_data",  {16'd0, c1_rsp_data}, 32'h5555);
      chk("t2_c0_rsp_clear", {31'd0, c0_rsp_valid}, 0);
      nxt();

      // Both streaming: one read per cycle, grants alternate c0,c1,...
      a0 = 7'd4;  a1 = 7'd10;
      c0_req_valid = 1'b1;  c0_req_addr = a0;
      c1_req_valid = 1'b1;  c1_req_addr = a1;
      for (int i = 0; i < 12; i++) begin
         smp();
         chk("t3_rden",     {31'd0, ram_rden}, 1);
         chk("t3_c0_grant", {31'd0, c0_req_ready}, {31'd0, (i % 2 == 0)});
         chk("t3_c1_grant", {31'd0, c1_req_ready}, {31'd0, (i % 2 == 1)});
         nxt();
         if (i % 2 == 0) a0 = a0 + 7'd1; else a1 = a1 + 7'd1;
         c0_req_addr = a0;
         c1_req_addr = a1;
      end
      c0_req_valid = 1'b0;  c1_req_valid = 1'b0;
      repeat (4) nxt();

      // c1 stalls its response; c0 keeps being served.
      c1_rsp_ready = 1'b0;
      c1_req_valid = 1'b1;  c1_req_addr = 7'd3;
      smp();
      chk("t4_c1_alone", {31'd0, c1_req_ready}, 1);
      nxt();
      c1_req_addr  = 7'd2;
      c0_req_valid = 1'b1;  c0_req_addr = 7'd1;
      c0_cnt = 0;
      for (int j = 1; j <= 8; j++) begin
         smp();
         chk("t4_c1_blocked", {31'd0, c1_req_ready}, 0);
         if (j >= 2) begin
            chk("t4_c1_rsp_valid", {31'd0, c1_rsp_valid}, 1);
            chk("t4_c1_rsp_data",  {16'd0, c1_rsp_data}, 32'hFFFF);
         end
         if (c0_req_valid && c0_req_ready) c0_cnt++;
         nxt();
      end
      chk("t4_c0_served", c0_cnt, 4);
      c0_req_valid = 1'b0;
      c1_rsp_ready = 1'b1;
      smp();
      chk("t4_c0_no_ready", {31'd0, c0_req_ready}, 0);
      chk("t4_c1_unblock",  {31'd0, c1_req_ready}, 1);
      chk("t4_rdaddr",      {25'd0, ram_rdaddr}, 2);
      nxt();
      c1_req_valid = 1'b0;
      repeat (4) nxt();

      // Reset during the data cycle of a c0 read.
      c0_req_valid = 1'b1;  c0_req_addr = 7'd1;
      smp();
      chk("t5_c0_grant", {31'd0, c0_req_ready}, 1);
      nxt();
      reset = 1'b1;
      c1_req_valid = 1'b1;  c1_req_addr = 7'd2;
      smp();
      chk("t5_rst_c0_ready", {31'd0, c0_req_ready}, 0);
      chk("t5_rst_c1_ready", {31'd0, c1_req_ready}, 0);
      chk("t5_rst_rden",     {31'd0, ram_rden}, 0);
      nxt();
      smp();
      chk("t5_rst_rsp_valid", {31'd0, c0_rsp_valid}, 0);
      chk("t5_rst_rden2",     {31'd0, ram_rden}, 0);
      nxt();
      reset = 1'b0;
      smp();
      chk("t5_tie_c0",     {31'd0, c0_req_ready}, 1);
      chk("t5_tie_c1",     {31'd0, c1_req_ready}, 0);
      chk("t5_no_stale",   {31'd0, c0_rsp_valid}, 0);
      nxt();
      c0_req_valid = 1'b0;
      smp();
      chk("t5_c1_next",    {31'd0, c1_req_ready}, 1);
      chk("t5_no_stale2",  {31'd0, c0_rsp_valid}, 0);
      nxt();
      c1_req_valid = 1'b0;
      smp();
      chk("t5_c0_rsp_valid", {31'd0, c0_rsp_valid}, 1);
      chk("t5_c0_rsp_data",  {16'd0, c0_rsp_data}, 32'hAAAA);
      nxt();
      smp();
      chk("t5_c1_rsp_data",  {16'd0, c1_rsp_data}, 32'h5555);
      repeat (3) nxt();

      smp();
      chk("c0_all_delivered", pend_cnt[0], 0);
      chk("c1_all_delivered", pend_cnt[1], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
